// File: rtl/rtc_resp_pkg.sv
// Shared definitions for the RTC bus responder.
//   state_e    : responder FSM states (IDLE, ADDR, DATA, RD_DRIVE)
//   REG_AW_DEF : default register-file address width
//   DATA_W_DEF : default bus width (address and data share the bus)
package rtc_resp_pkg;

    localparam int REG_AW_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADDR     = 2'd1,
        DATA     = 2'd2,
        RD_DRIVE = 2'd3
    } state_e;

endpackage

// File: rtl/rtc_sync_edge.sv
// Synchronizer chain for one active-low bus strobe, followed by an edge
// detector on the synchronized level.
// Ports:
//   clk_i    : system clock
//   reset_i  : synchronous active-high reset (chain returns to the idle level)
//   strobe_i : asynchronous strobe from the pins
//   lvl_o    : synchronized level (SYNC_STAGES clocks behind the pin)
//   rise_o   : one-cycle pulse while the synchronized level goes 0->1
//   fall_o   : one-cycle pulse while the synchronized level goes 1->0
module rtc_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit IDLE_LVL    = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic strobe_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to the idle (deasserted) level so no spurious edge appears when
    // reset releases with the strobes parked high.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = lvl_o & ~prev_q;
    assign fall_o = ~lvl_o & prev_q;

endmodule

// File: rtl/rtc_bus_responder.sv
// Responder end of the multiplexed address/data RTC bus. Decodes the
// active-low CS/WR/RD strobes and the AD phase select into address, write
// and read phases backed by a 2**REG_AW entry register file.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   CS, WR, RD          : active-low chip select / write / read strobes
//   AD                  : 0 = address phase, 1 = data phase (fixed at CS fall)
//   dat_in              : bus value at the pins
//   dat_out, dat_oe     : registered read data and tri-state enable
//   upd_valid/addr/data : one-cycle notification of a committed write
//   err                 : sticky protocol-error flag
// Build option: define RTC_RESP_CHECK_EN to include the protocol checker
// driving err; without it err is tied low.
module rtc_bus_responder
    import rtc_resp_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CS,
    input  logic              WR,
    input  logic              RD,
    input  logic              AD,
    input  logic [DATA_W-1:0] dat_in,
    output logic [DATA_W-1:0] dat_out,
    output logic              dat_oe,
    output logic              upd_valid,
    output logic [REG_AW-1:0] upd_addr,
    output logic [DATA_W-1:0] upd_data,
    output logic              err
);

    localparam int DEPTH = 2 ** REG_AW;

    // Any address bit above the register-file range marks the address as
    // out of range.
    function automatic logic addr_oor(input logic [DATA_W-1:0] v);
        return |(v >> REG_AW);
    endfunction

    // ---------------- strobe synchronizers ----------------
    logic cs_lvl, cs_rise, cs_fall;
    logic wr_lvl, wr_rise, wr_fall;
    logic rd_lvl, rd_rise, rd_fall;
    logic ad_lvl, ad_rise, ad_fall;

    rtc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_cs (
        .clk_i(clk), .reset_i(reset), .strobe_i(CS),
        .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    rtc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_wr (
        .clk_i(clk), .reset_i(reset), .strobe_i(WR),
        .lvl_o(wr_lvl), .rise_o(wr_rise), .fall_o(wr_fall)
    );
    rtc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_rd (
        .clk_i(clk), .reset_i(reset), .strobe_i(RD),
        .lvl_o(rd_lvl), .rise_o(rd_rise), .fall_o(rd_fall)
    );
    rtc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_ad (
        .clk_i(clk), .reset_i(reset), .strobe_i(AD),
        .lvl_o(ad_lvl), .rise_o(ad_rise), .fall_o(ad_fall)
    );

    // WR is consumed as a level only; its edge pulses are not needed.
    logic unused_wr_edges;
    assign unused_wr_edges = wr_rise ^ wr_fall;

    // ---------------- FSM and window tracking ----------------
    state_e              state_q, state_d;
    logic [REG_AW-1:0]   addr_q, addr_d;
    logic                oor_q, oor_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic                wr_seen_q, wr_seen_d;
    logic                both_q, both_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic                win_seen;
    logic                win_both;
    logic [DATA_W-1:0]   win_cap;
    logic                commit;
    logic                wr_commit;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        oor_d     = oor_q;
        cap_d     = cap_q;
        wr_seen_d = wr_seen_q;
        both_d    = both_q;
        commit    = 1'b0;
        // Window state including the current sample, so a WR still low on
        // the CS-rise cycle counts as the last WR-low cycle.
        win_seen  = wr_seen_q | ~wr_lvl;
        win_both  = both_q | (~wr_lvl & ~rd_lvl);
        win_cap   = ~wr_lvl ? dat_in : cap_q;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ad_lvl ? DATA : ADDR;
                    wr_seen_d = ~wr_lvl;
                    both_d    = ~wr_lvl & ~rd_lvl;
                    cap_d     = win_cap;
                end
            end
            ADDR: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    if (win_seen) begin
                        addr_d = win_cap[REG_AW-1:0];
                        oor_d  = addr_oor(win_cap);
                    end
                end else begin
                    wr_seen_d = win_seen;
                    cap_d     = win_cap;
                end
            end
            DATA: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    commit  = win_seen & ~win_both;
                end else begin
                    wr_seen_d = win_seen;
                    both_d    = win_both;
                    cap_d     = win_cap;
                    if (rd_fall && wr_lvl && !win_both) begin
                        state_d = RD_DRIVE;
                    end
                end
            end
            RD_DRIVE: begin
                if (cs_rise || rd_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range writes are dropped silently.
    assign wr_commit = commit & ~oor_q;

    // ---------------- state / register file ----------------
    logic                pend_q;
    logic [REG_AW-1:0]   pend_addr_q;
    logic [DATA_W-1:0]   pend_data_q;
    logic                upd_valid_q;
    logic [REG_AW-1:0]   upd_addr_q;
    logic [DATA_W-1:0]   upd_data_q;
    logic                dat_oe_q;
    logic [DATA_W-1:0]   dat_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            oor_q       <= 1'b0;
            cap_q       <= '0;
            wr_seen_q   <= 1'b0;
            both_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            upd_valid_q <= 1'b0;
            upd_addr_q  <= '0;
            upd_data_q  <= '0;
            dat_oe_q    <= 1'b0;
            dat_out_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            oor_q     <= oor_d;
            cap_q     <= cap_d;
            wr_seen_q <= wr_seen_d;
            both_q    <= both_d;
            if (wr_commit) begin
                regs_q[addr_q] <= win_cap;
            end
            // ---- output stage: one clock after the FSM transition ----
            pend_q <= wr_commit;
            if (wr_commit) begin
                pend_addr_q <= addr_q;
                pend_data_q <= win_cap;
            end
            upd_valid_q <= pend_q;
            if (pend_q) begin
                upd_addr_q <= pend_addr_q;
                upd_data_q <= pend_data_q;
            end
            // Read data is frozen for the whole drive window: no write can
            // commit while the FSM sits in RD_DRIVE.
            dat_oe_q  <= (state_q == RD_DRIVE);
            dat_out_q <= (state_q == RD_DRIVE && !oor_q) ? regs_q[addr_q] : '0;
        end
    end

    assign dat_out   = dat_out_q;
    assign dat_oe    = dat_oe_q;
    assign upd_valid = upd_valid_q;
    assign upd_addr  = upd_addr_q;
    assign upd_data  = upd_data_q;

    // ---------------- protocol checker ----------------
`ifdef RTC_RESP_CHECK_EN
    logic err_q;
    logic err_set;

    always_comb begin
        err_set = 1'b0;
        // Phase select must not move while the cycle is open.
        if (state_q != IDLE && !cs_lvl && (ad_rise || ad_fall)) begin
            err_set = 1'b1;
        end
        if (state_q != IDLE && !wr_lvl && !rd_lvl) begin
            err_set = 1'b1;
        end
        if (state_q == ADDR && !rd_lvl) begin
            err_set = 1'b1;
        end
        if (state_q == ADDR && cs_rise && !win_seen) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_ad_edges;
    assign unused_ad_edges = ad_rise ^ ad_fall;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_responder.sv
module tb_rtc_bus_responder;

    localparam int REG_AW      = 4;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 2;
    localparam int MAXC        = 8192;
`ifdef RTC_RESP_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              CS = 1'b1, WR = 1'b1, RD = 1'b1, AD = 1'b0;
    logic [DATA_W-1:0] dat_in = '0;
    logic [DATA_W-1:0] dat_out;
    logic              dat_oe;
    logic              upd_valid;
    logic [REG_AW-1:0] upd_addr;
    logic [DATA_W-1:0] upd_data;
    logic              err;

    rtc_bus_responder #(
        .REG_AW(REG_AW), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset(reset), .CS(CS), .WR(WR), .RD(RD), .AD(AD),
        .dat_in(dat_in), .dat_out(dat_out), .dat_oe(dat_oe),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: register contents, current address, and the
    // expected output waveform per clock cycle.
    logic [DATA_W-1:0] model_regs [16];
    logic [3:0]        model_addr;
    logic              model_oor;
    bit                exp_oe  [MAXC];
    logic [DATA_W-1:0] exp_out [MAXC];
    bit                exp_upd [MAXC];
    logic [REG_AW-1:0] exp_ua  [MAXC];
    logic [DATA_W-1:0] exp_ud  [MAXC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            check("dat_oe", {31'd0, dat_oe}, {31'd0, exp_oe[cyc]});
            if (exp_oe[cyc]) check("dat_out", dat_out, exp_out[cyc]);
            check("upd_valid", {31'd0, upd_valid}, {31'd0, exp_upd[cyc]});
            if (exp_upd[cyc]) begin
                check("upd_addr", upd_addr, exp_ua[cyc]);
                check("upd_data", upd_data, exp_ud[cyc]);
            end
        end
    end

    task automatic addr_phase(input logic [7:0] a, input int wl);
        AD = 1'b0; dat_in = a;
        tick(2);
        CS = 1'b0; tick(1);
        WR = 1'b0; tick(wl);
        WR = 1'b1; tick(1);
        CS = 1'b1;
        model_addr = a[3:0];
        model_oor  = (a > 8'd15);
        tick(LAT + 2);
    endtask

    task automatic write_phase(input logic [7:0] d, input int wl);
        int kr;
        AD = 1'b1; dat_in = d;
        tick(2);
        CS = 1'b0; tick(1);
        WR = 1'b0; tick(wl);
        WR = 1'b1; tick(1);
        CS = 1'b1;
        kr = cyc;
        if (!model_oor) begin
            model_regs[model_addr] = d;
            if (kr + LAT < MAXC) begin
                exp_upd[kr + LAT] = 1'b1;
                exp_ua[kr + LAT]  = model_addr;
                exp_ud[kr + LAT]  = d;
            end
        end
        tick(LAT + 2);
    endtask

    task automatic read_phase(input int len, input bit pin, input logic [7:0] lit);
        int r0;
        logic [7:0] v;
        AD = 1'b1;
        tick(2);
        CS = 1'b0; tick(1);
        RD = 1'b0;
        r0 = cyc;
        v = model_oor ? 8'h00 : model_regs[model_addr];
        for (int i = 0; i < len; i++) begin
            if (r0 + LAT + i < MAXC) begin
                exp_oe[r0 + LAT + i]  = 1'b1;
                exp_out[r0 + LAT + i] = v;
            end
        end
        for (int i = 0; i <= len + LAT + 3; i++) begin
            if (i == len) RD = 1'b1;
            if (i == len + 1) CS = 1'b1;
            if (pin && i == LAT - 1) check("rd_oe_before", {31'd0, dat_oe}, 32'd0);
            if (pin && i == LAT) begin
                check("rd_oe_first", {31'd0, dat_oe}, 32'd1);
                check("rd_out_lit", dat_out, lit);
            end
            if (pin && i == len + LAT) check("rd_oe_after", {31'd0, dat_oe}, 32'd0);
            tick(1);
        end
    endtask

    task automatic both_phase(input logic [7:0] d);
        AD = 1'b1; dat_in = d;
        tick(2);
        CS = 1'b0; tick(1);
        WR = 1'b0; RD = 1'b0; tick(3);
        WR = 1'b1; RD = 1'b1; tick(1);
        CS = 1'b1;
        tick(LAT + 2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_addr = '0;
        model_oor  = 1'b0;

        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("rst_err", {31'd0, err}, 32'd0);
            check("rst_dat_out", dat_out, 32'd0);
            check("rst_upd_addr", upd_addr, 32'd0);
            check("rst_upd_data", upd_data, 32'd0);
        end

        // Write 0x3C to register 5, then read it back for 7 clocks.
        addr_phase(8'h05, 3);
        write_phase(8'h3C, 3);
        check("wr5_upd_addr", upd_addr, 32'h5);
        check("wr5_upd_data", upd_data, 32'h3C);
        addr_phase(8'h05, 2);
        read_phase(7, 1'b1, 8'h3C);

        // Out-of-range address: write dropped, read returns zero.
        addr_phase(8'h20, 3);
        write_phase(8'h77, 3);
        check("oor_upd_addr_held", upd_addr, 32'h5);
        check("oor_upd_data_held", upd_data, 32'h3C);
        read_phase(4, 1'b1, 8'h00);
        addr_phase(8'h00, 2);
        read_phase(3, 1'b1, 8'h00);

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                logic [7:0] a;
                a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255))
                                                : 8'($urandom_range(0, 15));
                addr_phase(a, int'($urandom_range(2, 5)));
            end else if (kind == 1) begin
                write_phase(8'($urandom_range(0, 255)), int'($urandom_range(2, 5)));
            end else begin
                read_phase(int'($urandom_range(1, 8)), 1'b0, 8'h00);
            end
        end
        check("err_clean", {31'd0, err}, 32'd0);

        // WR and RD low together: no write, no drive, error flagged.
        addr_phase(8'h03, 2);
        write_phase(8'h11, 2);
        both_phase(8'h99);
        read_phase(3, 1'b1, 8'h11);
        check("err_both", {31'd0, err}, {31'd0, ERR_EXP});

        // Reset two clocks into RD_DRIVE.
        AD = 1'b1;
        tick(2);
        CS = 1'b0; tick(1);
        RD = 1'b0;
        r0 = cyc;
        exp_oe[r0 + LAT]      = 1'b1;
        exp_out[r0 + LAT]     = 8'h11;
        exp_oe[r0 + LAT + 1]  = 1'b1;
        exp_out[r0 + LAT + 1] = 8'h11;
        tick(LAT + 1);
        check("rst_mid_oe_high", {31'd0, dat_oe}, 32'd1);
        reset = 1'b1; CS = 1'b1; RD = 1'b1;
        tick(1);
        check("rst_mid_oe_drop", {31'd0, dat_oe}, 32'd0);
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_addr = '0;
        model_oor  = 1'b0;
        tick(3);
        check("rst_mid_err", {31'd0, err}, 32'd0);
        read_phase(3, 1'b1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Responder end of the multiplexed address/data RTC bus driven by the control-signal generator. Decodes the active-low CS, WR, RD and AD strobes into address phases, write data phases and read data phases. Backs them with an internal register file and drives read data onto the tri-state bus through an output-enable. Used as the on-chip RTC model for closed-loop simulation and as a register slave for any block that speaks the same bus.

## Interface
- REG_AW, 4: register file address width; depth = 2**REG_AW.
- DATA_W, 8: bus width, which covers both address and data.
- SYNC_STAGES, 2: synchronizer depth on CS/WR/RD/AD, ≥2.
- clk  in  1  system clock.
- reset  in  1  reset; one clock, reset is synchronous and active-high.
- CS  in  1  chip select, active low.
- WR  in  1  write strobe, active low.
- RD  in  1  read strobe, active low.
- AD  in  1  0 = address phase, 1 = data phase.
- dat_in  in  DATA_W  bus value as seen at the pins.
- dat_out  out  DATA_W  read data for the bus driver.
- dat_oe  out  1  tri-state enable for dat_out.
- upd_valid  out  1  one-cycle pulse when a register is written.
- upd_addr  out  REG_AW  address of that write.
- upd_data  out  DATA_W  data of that write.
- err  out  1  sticky protocol-error flag.

## Operation
- All four strobes pass through SYNC_STAGES flops and then an edge detector. dat_in is sampled in the same cycle as the synchronized strobes.
- FSM states:
  - IDLE → ADDR when CS falls with AD=0.
  - IDLE → DATA when CS falls with AD=1.
  - ADDR → IDLE on CS rise. If WR was low at any point in the window, addr_reg ← dat_in[REG_AW-1:0] captured on the last WR-low cycle. The upper address bits are latched into oor (out-of-range) = |dat_in[DATA_W-1:REG_AW].
  - DATA → RD_DRIVE when RD falls while WR is high.
  - DATA → IDLE on CS rise. If WR was low in the window, the write commits on CS rise with the data captured on the last WR-low cycle.
  - RD_DRIVE → IDLE when RD or CS rises.
- Write commit with oor=0: regs[addr_reg] ← data, and a upd_valid pulse is issued. With oor=1 the write is dropped and no pulse is issued.
- Read: dat_out = regs[addr_reg], or 0 when oor=1. dat_out is registered and stable for the whole of RD_DRIVE.
- addr_reg persists across data phases. Repeated data phases reuse the last address.
- Simultaneous events:
  - WR and RD both low in one data window: nothing is written, dat_oe stays 0, and the cycle counts as an error.
  - CS rising and falling within one synchronized sample: treated as two separate cycles. No merge.
  - AD toggling while CS is low: the phase is fixed by AD at the CS fall, and the cycle counts as an error.
- Reset mid-operation: the state returns to IDLE on the next edge, dat_oe drops, and no commit happens.
- Reset values: dat_out=0, dat_oe=0, upd_valid=0, upd_addr=0, upd_data=0, err=0, addr_reg=0, oor=0, regs all 0, state IDLE.

## Timing
- Strobe-to-internal latency is SYNC_STAGES+1 clocks from a pin edge.
- dat_oe rises 1 clock after the FSM enters RD_DRIVE, which is SYNC_STAGES+2 clocks after the RD pin falls. dat_oe falls SYNC_STAGES+2 clocks after RD or CS rises.
- upd_valid pulses exactly 1 clock, SYNC_STAGES+2 clocks after the CS pin rise that commits the write.
- A data phase must keep CS low for at least SYNC_STAGES+2 clocks, or the cycle is lost.

## Configuration
- RTC_RESP_CHECK_EN defined: err sets on any of the following, and clears only on reset:
  - WR and RD both low in a window.
  - AD change while CS is low.
  - RD low during ADDR.
  - CS rise in ADDR without WR low.
- RTC_RESP_CHECK_EN undefined: err is tied to 0 and the checker logic is absent. Functional behaviour is otherwise identical.

## Structure
- Package rtc_resp_pkg holds the state enum (IDLE, ADDR, DATA, RD_DRIVE) and the default width constants REG_AW_DEF and DATA_W_DEF.
- Sub-module rtc_sync_edge contains one synchronizer chain plus rise/fall pulse outputs. It is instantiated four times, once each for CS, WR, RD and AD.

## Test plan
- Reset with strobes idle high → all outputs 0, err=0, dat_oe=0 for 20 clocks.
- Address phase with dat_in=0x05, then a write data phase with dat_in=0x3C → upd_valid single pulse with upd_addr=5, upd_data=0x3C; regs[5]=0x3C.
- Address 0x05, then a read data phase with RD low for 7 clocks → dat_oe high for 7 clocks with the stated latency, dat_out=0x3C throughout; dat_oe=0 afterwards.
- Address 0x20 (REG_AW=4), write 0x77, then read → no upd_valid, dat_out=0x00 during the read, regs unchanged.
- Data window with WR and RD both low → no write, dat_oe=0; err=1 with RTC_RESP_CHECK_EN, err=0 without it.
- Reset asserted 2 clocks into RD_DRIVE → dat_oe=0 the next clock, state IDLE, and a following read of address 0 returns 0x00.
